// File: rtl/ring_mem_ctrl.sv
// Beehive ring memory controller at ring position 0: captures Address/WriteData slots,
// keeps a per-line coherence directory, streams read lines and issues grants/retries.
module ring_mem_ctrl #(
  parameter int MBITS         = 24,
  parameter int LINE_LOG      = 3,
  parameter int MA_LOG        = 9,
  parameter int MD_LOG        = 12,
  parameter int INIT_MODIFIED = 128
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] RingIn,
  input  logic [3:0]  SlotTypeIn,
  input  logic [3:0]  SourceIn,
  output logic [31:0] RDreturn,
  output logic [3:0]  RDdest,
  output logic        wrResendQ,
  output logic [39:0] resendQin,
  input  logic        resendQfull,
  output logic        initDone,
  output logic        errPulse,
  output logic [15:0] errCount
);

  localparam int          LW         = MBITS - LINE_LOG;
  localparam int          NLINES     = 1 << LW;
  localparam logic [31:0] INIT_MOD   = 32'(INIT_MODIFIED);
  localparam logic [1:0]  CLEAN      = 2'd0;
  localparam logic [1:0]  WAITING    = 2'd1;
  localparam logic [1:0]  MODIFIED   = 2'd2;
  localparam logic [3:0]  SLOT_ADDR  = 4'd2;
  localparam logic [3:0]  SLOT_WDATA = 4'd3;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_SEND, S_WRITE, S_DRAIN} state_t;

  state_t state, state_next;

  logic [35:0]         ma_mem [1 << MA_LOG];
  logic [MA_LOG:0]     ma_wr, ma_rd;
  logic                ma_empty, ma_full, ma_push, ma_pop, ma_drop;
  logic [31:0]         md_mem [1 << MD_LOG];
  logic [MD_LOG:0]     md_wr, md_rd;
  logic                md_empty, md_full, md_push, md_pop, md_drop;

  logic [1:0]          dir [NLINES];
  logic [31:0]         mem [1 << MBITS];

  logic [LW-1:0]       init_idx;
  logic [LINE_LOG-1:0] cnt, cnt_next;

  logic [35:0]         head;
  logic [3:0]          head_dest;
  logic [31:0]         head_word;
  logic [LW-1:0]       head_line;
  logic                head_valid;
  logic [1:0]          head_dir;
  logic                read_possible;
  logic [31:0]         md_head;
  logic [MBITS-1:0]    word_addr;

  logic                dir_we;
  logic [LW-1:0]       dir_waddr;
  logic [1:0]          dir_wdata;
  logic                mem_we;
  logic                send;
  logic                bad_req;
  logic [1:0]          err_inc;

  // A slot arriving at a full FIFO is dropped and counted, never written.
  assign ma_empty = (ma_wr == ma_rd);
  assign ma_full  = ((ma_wr ^ ma_rd) == {1'b1, {MA_LOG{1'b0}}});
  assign ma_push  = !reset && (SlotTypeIn == SLOT_ADDR) && !ma_full;
  assign ma_drop  = !reset && (SlotTypeIn == SLOT_ADDR) && ma_full;
  assign md_empty = (md_wr == md_rd);
  assign md_full  = ((md_wr ^ md_rd) == {1'b1, {MD_LOG{1'b0}}});
  assign md_push  = !reset && (SlotTypeIn == SLOT_WDATA) && !md_full;
  assign md_drop  = !reset && (SlotTypeIn == SLOT_WDATA) && md_full;

  assign head          = ma_mem[ma_rd[MA_LOG-1:0]];
  assign head_dest     = head[35:32];
  assign head_word     = head[31:0];
  assign head_line     = head_word[LW-1:0];
  assign head_valid    = (head_word[27:LW] == '0);
  assign head_dir      = dir[head_line];
  assign read_possible = (head_dir == CLEAN) || ((head_dir == WAITING) && head_word[31]);
  assign md_head       = md_mem[md_rd[MD_LOG-1:0]];
  assign word_addr     = {head_line, cnt};
  assign err_inc       = {1'b0, ma_drop} + {1'b0, md_drop} + {1'b0, bad_req};

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ma_pop     = 1'b0;
    md_pop     = 1'b0;
    wrResendQ  = 1'b0;
    resendQin  = '0;
    dir_we     = 1'b0;
    dir_waddr  = head_line;
    dir_wdata  = CLEAN;
    mem_we     = 1'b0;
    send       = 1'b0;
    bad_req    = 1'b0;
    if (!reset) begin
      case (state)
        S_INIT: begin
          dir_we    = 1'b1;
          dir_waddr = init_idx;
          dir_wdata = (32'(init_idx) < INIT_MOD) ? MODIFIED : CLEAN;
          if (&init_idx) state_next = S_IDLE;
        end
        S_IDLE: begin
          if (!ma_empty) begin
            cnt_next = '0;
            if (!head_valid) begin
              ma_pop  = 1'b1;
              bad_req = 1'b1;
              if (!head_word[28]) state_next = S_DRAIN;
            end else if (head_word[28]) begin
              // Retries and grants are held at the head while the resend queue is full.
              if (!read_possible) begin
                if (!resendQfull) begin
                  wrResendQ = 1'b1;
                  resendQin = {head_dest, 4'h2, 2'b10, head_word[29:0]};
                  ma_pop    = 1'b1;
                end
              end else if (head_word[30]) begin
                if (!resendQfull) begin
                  wrResendQ = 1'b1;
                  resendQin = {head_dest, 4'h6, 4'h0, head_word[27:0]};
                  ma_pop    = 1'b1;
                  dir_we    = 1'b1;
                  dir_wdata = head_word[29] ? MODIFIED : CLEAN;
                end
              end else begin
                dir_we     = 1'b1;
                dir_wdata  = head_word[29] ? MODIFIED : CLEAN;
                state_next = S_SEND;
              end
            end else begin
              dir_we     = 1'b1;
              dir_wdata  = head_word[29] ? WAITING : CLEAN;
              state_next = S_WRITE;
            end
          end
        end
        S_SEND: begin
          send     = 1'b1;
          cnt_next = cnt + 1'b1;
          if (&cnt) begin
            ma_pop     = 1'b1;
            state_next = S_IDLE;
          end
        end
        S_WRITE, S_DRAIN: begin
          // Stall with the count held until the next data word is present.
          if (!md_empty) begin
            md_pop   = 1'b1;
            mem_we   = (state == S_WRITE);
            cnt_next = cnt + 1'b1;
            if (&cnt) begin
              ma_pop     = (state == S_WRITE);
              state_next = S_IDLE;
            end
          end
        end
        default: state_next = S_INIT;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ma_wr <= '0;
      ma_rd <= '0;
      md_wr <= '0;
      md_rd <= '0;
    end else begin
      if (ma_push) ma_wr <= ma_wr + 1'b1;
      if (ma_pop)  ma_rd <= ma_rd + 1'b1;
      if (md_push) md_wr <= md_wr + 1'b1;
      if (md_pop)  md_rd <= md_rd + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (ma_push) ma_mem[ma_wr[MA_LOG-1:0]] <= {SourceIn, RingIn};
    if (md_push) md_mem[md_wr[MD_LOG-1:0]] <= RingIn;
    if (dir_we)  dir[dir_waddr] <= dir_wdata;
    if (mem_we)  mem[word_addr] <= md_head;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_INIT;
      cnt      <= '0;
      init_idx <= '0;
      initDone <= 1'b0;
      RDreturn <= '0;
      RDdest   <= '0;
      errPulse <= 1'b0;
      errCount <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      if (state == S_INIT) init_idx <= init_idx + 1'b1;
      if ((state == S_INIT) && (state_next == S_IDLE)) initDone <= 1'b1;
      RDdest   <= send ? head_dest : 4'd0;
      RDreturn <= send ? mem[word_addr] : '0;
      errPulse <= (err_inc != 2'd0);
      if ((32'(errCount) + 32'(err_inc)) > 32'h0000_FFFF) errCount <= '1;
      else errCount <= errCount + 16'(err_inc);
    end
  end

endmodule

// File: tb/tb_ring_mem_ctrl.sv
// Self-checking bench for ring_mem_ctrl: directed scenarios plus randomized requests
// checked against a line-level directory/memory model.
module tb_ring_mem_ctrl;

  localparam int MBITS         = 12;
  localparam int LINE_LOG      = 3;
  localparam int MA_LOG        = 3;
  localparam int MD_LOG        = 4;
  localparam int INIT_MODIFIED = 128;
  localparam int NLINES        = 512;
  localparam int WORDS         = 8;
  localparam logic [3:0] T_ADDR  = 4'd2;
  localparam logic [3:0] T_WDATA = 4'd3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] RingIn = '0;
  logic [3:0]  SlotTypeIn = '0;
  logic [3:0]  SourceIn = '0;
  logic        resendQfull = 1'b0;
  logic [31:0] RDreturn;
  logic [3:0]  RDdest;
  logic        wrResendQ;
  logic [39:0] resendQin;
  logic        initDone;
  logic        errPulse;
  logic [15:0] errCount;

  ring_mem_ctrl #(
    .MBITS(MBITS), .LINE_LOG(LINE_LOG), .MA_LOG(MA_LOG), .MD_LOG(MD_LOG),
    .INIT_MODIFIED(INIT_MODIFIED)
  ) dut (
    .clock(clock), .reset(reset), .RingIn(RingIn), .SlotTypeIn(SlotTypeIn),
    .SourceIn(SourceIn), .RDreturn(RDreturn), .RDdest(RDdest), .wrResendQ(wrResendQ),
    .resendQin(resendQin), .resendQfull(resendQfull), .initDone(initDone),
    .errPulse(errPulse), .errCount(errCount)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  logic [35:0] rd_q [$];
  int          rd_cyc [$];
  logic [39:0] rs_q [$];
  int          rs_cyc [$];
  int          err_pulses = 0;
  int          push_while_full = 0;

  // Observed read words, resend pushes and error pulses, sampled mid-cycle.
  always @(negedge clock) begin
    if (!reset) begin
      if (RDdest != 4'd0) begin
        rd_q.push_back({RDdest, RDreturn});
        rd_cyc.push_back(cyc);
      end
      if (wrResendQ) begin
        rs_q.push_back(resendQin);
        rs_cyc.push_back(cyc);
        if (resendQfull) push_while_full++;
      end
      if (errPulse) err_pulses++;
    end
  end

  logic [1:0]  dir_m [NLINES];
  logic [31:0] mem_m [int];
  int          err_total;
  logic [31:0] wdata [WORDS];
  int          addr_cyc;

  function automatic void initModel();
    for (int i = 0; i < NLINES; i++) dir_m[i] = (i < INIT_MODIFIED) ? 2'd2 : 2'd0;
    err_total = 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] t, input logic [3:0] s, input logic [31:0] d);
    SlotTypeIn = t;
    SourceIn   = s;
    RingIn     = d;
    @(posedge clock);
    #1;
    SlotTypeIn = '0;
    SourceIn   = '0;
    RingIn     = '0;
  endtask

  task automatic clearMon();
    rd_q.delete();
    rd_cyc.delete();
    rs_q.delete();
    rs_cyc.delete();
    err_pulses = 0;
    push_while_full = 0;
  endtask

  task automatic applyReset(output int init_cycles);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    init_cycles = 0;
    while (!initDone && init_cycles < 2000) begin
      @(posedge clock);
      #1;
      init_cycles++;
    end
  endtask

  // One request (plus its data words for a write), checked against the line-level model.
  task automatic runTxn(input logic [3:0] src, input logic [31:0] aw, input int gap, input string tag);
    logic [39:0] exp_rs;
    int          exp_rs_n, exp_words, exp_err, line;
    logic [31:0] exp_d [WORDS];
    bit          exp_k [WORDS];
    bit          possible;
    clearMon();
    line = int'(aw[27:0]);
    exp_rs = '0;
    exp_rs_n = 0;
    exp_words = 0;
    exp_err = 0;
    for (int i = 0; i < WORDS; i++) begin
      exp_k[i] = 1'b0;
      exp_d[i] = '0;
    end
    if (line >= NLINES) begin
      exp_err = 1;
    end else if (aw[28]) begin
      possible = (dir_m[line] == 2'd0) || ((dir_m[line] == 2'd1) && aw[31]);
      if (!possible) begin
        exp_rs_n = 1;
        exp_rs = {src, 4'h2, 2'b10, aw[29:0]};
      end else begin
        if (aw[30]) begin
          exp_rs_n = 1;
          exp_rs = {src, 4'h6, 4'h0, aw[27:0]};
        end else begin
          exp_words = WORDS;
          for (int i = 0; i < WORDS; i++) begin
            exp_k[i] = mem_m.exists(line * WORDS + i);
            if (exp_k[i]) exp_d[i] = mem_m[line * WORDS + i];
          end
        end
        dir_m[line] = aw[29] ? 2'd2 : 2'd0;
      end
    end else begin
      dir_m[line] = aw[29] ? 2'd1 : 2'd0;
      for (int i = 0; i < WORDS; i++) mem_m[line * WORDS + i] = wdata[i];
    end
    err_total += exp_err;
    addr_cyc = cyc;
    applyStimulus(T_ADDR, src, aw);
    if (!aw[28]) begin
      for (int i = 0; i < WORDS; i++) begin
        idle(gap);
        applyStimulus(T_WDATA, src, wdata[i]);
      end
    end
    idle(20);
    checkOutput({tag, " words"}, 64'(rd_q.size()), 64'(exp_words));
    for (int i = 0; i < rd_q.size() && i < exp_words; i++) begin
      checkOutput({tag, " dest"}, 64'(rd_q[i][35:32]), 64'(src));
      if (exp_k[i]) checkOutput({tag, " data"}, 64'(rd_q[i][31:0]), 64'(exp_d[i]));
      if (i > 0) checkOutput({tag, " spacing"}, 64'(rd_cyc[i] - rd_cyc[0]), 64'(i));
    end
    checkOutput({tag, " pushes"}, 64'(rs_q.size()), 64'(exp_rs_n));
    if (rs_q.size() > 0 && exp_rs_n > 0) checkOutput({tag, " resendQin"}, 64'(rs_q[0]), 64'(exp_rs));
    checkOutput({tag, " errPulse"}, 64'(err_pulses), 64'(exp_err));
    checkOutput({tag, " errCount"}, 64'(errCount), 64'(err_total));
  endtask

  task automatic fillData();
    for (int i = 0; i < WORDS; i++) wdata[i] = $urandom();
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          n;
    bit          got4;
    logic [3:0]  src;
    logic [31:0] aw;
    int          line;

    idle(2);
    checkOutput("reset RDdest", 64'(RDdest), 64'd0);
    checkOutput("reset RDreturn", 64'(RDreturn), 64'd0);
    checkOutput("reset wrResendQ", 64'(wrResendQ), 64'd0);
    checkOutput("reset resendQin", 64'(resendQin), 64'd0);
    checkOutput("reset initDone", 64'(initDone), 64'd0);
    checkOutput("reset errPulse", 64'(errPulse), 64'd0);
    checkOutput("reset errCount", 64'(errCount), 64'd0);

    applyReset(n);
    checkOutput("init cycles", 64'(n), 64'(NLINES));
    initModel();

    runTxn(4'd1, 32'h1000_0005, 0, "retry line5");
    if (rs_q.size() > 0) checkOutput("retry line5 literal", 64'(rs_q[0]), 64'h12_9000_0005);

    fillData();
    runTxn(4'd2, 32'h0000_00C8, 0, "write200");
    runTxn(4'd4, 32'h1000_00C8, 0, "read200");
    if (rd_q.size() > 0) checkOutput("read200 latency", 64'(rd_cyc[0] - addr_cyc), 64'd3);

    fillData();
    runTxn(4'd3, 32'h2000_012C, 1, "write300 gapped");
    runTxn(4'd5, 32'h1000_012C, 0, "read300 plain");
    runTxn(4'd5, 32'hB000_012C, 0, "read300 resent");
    runTxn(4'd5, 32'h9000_012C, 0, "read300 after modified");

    runTxn(4'd9, 32'h7000_0190, 0, "grant400");
    if (rs_q.size() > 0) checkOutput("grant400 literal", 64'(rs_q[0]), 64'h96_0000_0190);
    runTxn(4'd9, 32'h1000_0190, 0, "read400 after grant");

    fillData();
    runTxn(4'd2, 32'h0000_01FF, 0, "write511");
    fillData();
    runTxn(4'd2, 32'h0FFF_FFFF, 0, "bad write");
    checkOutput("bad write errCount", 64'(errCount), 64'd1);
    runTxn(4'd2, 32'h1000_01FF, 0, "read511 unchanged");

    clearMon();
    resendQfull = 1'b1;
    for (int k = 0; k < 3; k++) applyStimulus(T_ADDR, 4'd7, 32'h1000_0000);
    idle(6);
    checkOutput("held while full", 64'(rs_q.size()), 64'd0);
    resendQfull = 1'b0;
    idle(6);
    checkOutput("released pushes", 64'(rs_q.size()), 64'd3);
    for (int i = 0; i < rs_q.size(); i++) begin
      checkOutput("released resendQin", 64'(rs_q[i]), 64'({4'd7, 4'h2, 2'b10, 30'h1000_0000}));
      if (i > 0) checkOutput("released spacing", 64'(rs_cyc[i] - rs_cyc[0]), 64'(i));
    end
    checkOutput("push while full", 64'(push_while_full), 64'd0);

    clearMon();
    resendQfull = 1'b1;
    for (int k = 0; k < 10; k++) applyStimulus(T_ADDR, 4'd8, 32'h1000_0000);
    idle(3);
    err_total += 2;
    checkOutput("overflow errPulse", 64'(err_pulses), 64'd2);
    checkOutput("overflow errCount", 64'(errCount), 64'(err_total));
    checkOutput("overflow no push", 64'(rs_q.size()), 64'd0);
    resendQfull = 1'b0;
    idle(12);
    checkOutput("overflow retries", 64'(rs_q.size()), 64'(1 << MA_LOG));
    checkOutput("overflow push while full", 64'(push_while_full), 64'd0);

    clearMon();
    applyStimulus(T_ADDR, 4'd6, 32'h1000_00C8);
    got4 = 1'b0;
    for (int k = 0; k < 20 && !got4; k++) begin
      @(negedge clock);
      if (rd_q.size() >= 4) got4 = 1'b1;
    end
    checkOutput("send reached word4", 64'(got4), 64'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("reset mid-send RDdest", 64'(RDdest), 64'd0);
    checkOutput("reset mid-send initDone", 64'(initDone), 64'd0);
    applyReset(n);
    checkOutput("re-init cycles", 64'(n), 64'(NLINES));
    initModel();
    checkOutput("re-init errCount", 64'(errCount), 64'd0);
    runTxn(4'd6, 32'h1000_00C8, 0, "read200 after reset");

    for (int k = 0; k < 40; k++) begin
      src = 4'($urandom_range(1, 15));
      line = 120 + int'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) line = NLINES + int'($urandom_range(0, 1000));
      aw = '0;
      aw[31] = 1'($urandom_range(0, 1));
      aw[30] = ($urandom_range(0, 3) == 0);
      aw[29] = 1'($urandom_range(0, 1));
      aw[28] = ($urandom_range(0, 9) >= 4);
      aw[27:0] = 28'(line);
      fillData();
      runTxn(src, aw, int'($urandom_range(0, 2)), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ring_mem_ctrl.md
# ring_mem_ctrl

Parametrised, synthesizable ring memory controller for the Beehive coherent ring. It sits at ring position 0, after the last core. It captures Address and WriteData slots leaving the last core and keeps a per-line coherence directory. It streams read lines onto the pipelined RDreturn/RDdest bus and pushes grants and retries into the external resend queue. Compared with the earlier simulation-only controller it adds:
- parametrised line size, memory size and FIFO depths;
- backpressure instead of overflow;
- write-data underrun stall;
- out-of-range request rejection;
- a self-initialising directory.

## Interface
Parameters:
- MBITS, 24: log2 of memory size in 32-bit words.
- LINE_LOG, 3: log2 of words per cache line (1..4).
- MA_LOG, 9: log2 depth of the address FIFO.
- MD_LOG, 12: log2 depth of the write-data FIFO.
- INIT_MODIFIED, 128: number of lowest lines set to MODIFIED at reset; all other lines are set to CLEAN.

Ports:
- clock, in, 1: the single clock.
- reset, in, 1: synchronous, active-high.
- RingIn, in, 32: slot data from the last core.
- SlotTypeIn, in, 4: slot type (Address=2, WriteData=3).
- SourceIn, in, 4: slot source core.
- RDreturn, out, 32: read data word (registered).
- RDdest, out, 4: destination core; 0 means idle.
- wrResendQ, out, 1: resend queue write strobe.
- resendQin, out, 40: {dest[3:0], type[3:0], data[31:0]}.
- resendQfull, in, 1: resend queue full.
- initDone, out, 1: directory initialisation complete.
- errPulse, out, 1: one-cycle pulse when a request is dropped (out-of-range address or full FIFO).
- errCount, out, 16: saturating count of dropped requests.

## Operation
Address word fields:
- [31] resent: the request may be granted while the line is WAITING.
- [30] grant-only: grant the line without returning data.
- [29] exclusive.
- [28] read (1) or write (0).
- [27:0] line address.

Definitions:
- Directory codes: CLEAN=0, WAITING=1, MODIFIED=2, one 2-bit entry per line, 2^(MBITS-LINE_LOG) entries.
- Valid line address: bits [27:MBITS-LINE_LOG] are zero.
- readPossible: dir==CLEAN, or (dir==WAITING and addr[31]).

Input capture:
- Address slots are written to the ma FIFO as {SourceIn, RingIn}.
- WriteData slots are written to the md FIFO.
- A slot that arrives while its FIFO is full is discarded and raises errPulse; the FIFO is not corrupted.
- Both FIFOs are first-word-fall-through.

States:
- INIT: entered on reset; counter sweeps every directory entry, one per cycle. initDone=0. Slots are still captured into the FIFOs. After the last entry, go to IDLE and set initDone=1.
- IDLE, with the ma FIFO non-empty, handles the head entry in this order:
  - Invalid address: pop, errPulse, stay in IDLE. If it is a write, discard 2^LINE_LOG md words through DRAIN.
  - Read, not readPossible: needs resendQfull=0. Push {dest, 4'h2, 2'b10, addr[29:0]}, pop, stay in IDLE. Directory unchanged.
  - Read, readPossible, grant-only: needs resendQfull=0. Push {dest, 4'h6, 4'h0, addr[27:0]}, pop, stay in IDLE. dir <= addr[29] ? MODIFIED : CLEAN.
  - Read, readPossible, data: dir <= addr[29] ? MODIFIED : CLEAN. Go to SEND with word count 0.
  - Write: dir <= addr[29] ? WAITING : CLEAN. Go to WRITE with count 0.
  - Any case that needs a push while resendQfull=1: the head entry is held and nothing changes. No push is ever issued while full.
- SEND: one word per cycle, mem[{line, count}] returned to the head dest. After word 2^LINE_LOG-1, pop ma and go to IDLE.
- WRITE: each cycle with md non-empty, pop md into mem[{line, count}] and increment count. With md empty, stall and hold the count. After the last word, pop ma and go to IDLE.
- DRAIN: same as WRITE but discards the data.

## Timing
- Reset values: RDreturn=0, RDdest=0, wrResendQ=0, resendQin=0, initDone=0, errPulse=0, errCount=0, FIFOs empty, state INIT.
- Reset mid-operation abandons any line transfer and restarts INIT. Memory contents are not cleared.
- INIT lasts exactly 2^(MBITS-LINE_LOG) cycles after reset deasserts.
- An Address slot on RingIn at edge t is visible at the ma head at t+1. A request with an empty queue is decided in IDLE at t+1.
- RDreturn/RDdest are registered. The first word appears one cycle after the first SEND cycle, then one word per consecutive cycle with no gaps. Read latency is slot-to-first-word 3 cycles.
- The next request is handled on the cycle after the SEND or WRITE exit. A grant or retry costs 1 cycle.
- wrResendQ/resendQin are combinational in the decision cycle.
- errCount saturates at 16'hFFFF.
- Simultaneous Address and WriteData slots cannot occur (one slot per cycle). A simultaneous md push and pop keeps the FIFO count unchanged.

## Test plan
- After reset: initDone rises after 2^(MBITS-LINE_LOG) cycles. A read of line 5 then gets retry type 2 with bits [31:30]=10. A read of line 200 returns 8 words from mem[1600..1607] on 8 consecutive cycles with RDdest = source.
- Write to line 300 from core 3 with exclusive set, with the 8 data words arriving 2 cycles apart: the WRITE state stalls between words; memory is correct after the last word; dir=WAITING. A plain read of line 300 is retried. A read with [31]=1 is served and dir becomes MODIFIED.
- Grant-only exclusive read of line 400: one resend push {dest, 6, 0, 400}, no RDreturn activity, dir=MODIFIED.
- Hold resendQfull=1 and send 3 reads of line 0: no wrResendQ while full, ma holds 3 entries. Release: 3 pushes on consecutive cycles.
- Write to line address 28'h0FFFFFF with MBITS=24, followed by 8 data words: errPulse once, errCount=1, md drained, memory unchanged.
- Assert reset during word 4 of a SEND: RDdest=0 on the next cycle, INIT restarts, and a fresh read completes all 8 words.
